// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared Simple ALU types and constants for the sequential divider
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam int WIDTH = 6;
  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 6'h3F;
  localparam logic [2:0] LAST_ITER = 3'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// div_step : one restoring-division trial subtraction on a 6-bit ripple adder
// Revision: 1.0
// ============================================================================
module div_step
  import alu_pkg::*;
(
  input  logic [WIDTH:0]   rprime_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             no_borrow_o
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_b;

  // R' - D computed as R'[5:0] + ~D + 1; carry-out high means no borrow.
  assign w_b        = ~divisor_i;
  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    assign diff_o[i]    = rprime_i[i] ^ w_b[i] ^ w_carry[i];
    assign w_carry[i+1] = (rprime_i[i] & w_b[i]) | (w_carry[i] & (rprime_i[i] ^ w_b[i]));
  end

  assign no_borrow_o = w_carry[WIDTH] | rprime_i[WIDTH];

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider6.sv
`default_nettype none
// ============================================================================
// seq_divider6 : iterative 6-bit unsigned restoring divider, start/done handshake
// Revision: 1.0
// ============================================================================
module seq_divider6
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   w_rprime;
  logic [WIDTH-1:0] w_diff;
  logic             w_no_borrow;

  assign w_rprime = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_step u_div_step (
    .rprime_i    (w_rprime),
    .divisor_i   (d_q),
    .diff_o      (w_diff),
    .no_borrow_o (w_no_borrow)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
            q_d     = dividend;
            r_d     = '0;
            d_d     = divisor;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            quot_d  = DIV0_QUOTIENT;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      RUN: begin
        q_d   = {q_q[WIDTH-2:0], w_no_borrow};
        r_d   = w_no_borrow ? {1'b0, w_diff} : w_rprime;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_ITER) begin
          // Results publish on the same edge as the final iteration.
          state_d = DONE;
          done_d  = 1'b1;
          quot_d  = q_d;
          rem_d   = r_d[WIDTH-1:0];
          dbz_d   = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule : seq_divider6
`default_nettype wire

// File: doc/seq_divider6.md
# seq_divider6

Iterative 6-bit unsigned restoring divider for the Simple ALU. It is the inverse companion of the 6-bit ripple-carry adder: it performs one trial subtraction per cycle on a 6-bit ripple-carry datapath, and produces quotient and remainder after a fixed latency. The block sits beside the combinational adder in the ALU execute stage and uses a start/done handshake.

## Interface
- WIDTH, 6: operand width. Fixed at 6; the iteration count equals WIDTH.
- clk  in  1  single clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse. Sampled on the rising edge; accepted only in IDLE or DONE.
- dividend  in  6  unsigned dividend, captured on an accepted start.
- divisor  in  6  unsigned divisor, captured on an accepted start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  out  6  result quotient; holds until the next completion.
- remainder  out  6  result remainder; holds until the next completion.
- div_by_zero  out  1  set with done when the captured divisor was 0; holds until the next completion.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared.
- IDLE or DONE, start=1, divisor≠0:
  - load Q=dividend, R=0 (7-bit), D=divisor, count=0
  - go to RUN.
- IDLE or DONE, start=1, divisor=0:
  - go directly to DONE
  - quotient=6'h3F, remainder=dividend, div_by_zero=1.
- RUN, each cycle:
  - R' = {R[5:0], Q[5]}
  - T = R' − {0, D}
  - if there is no borrow (R'[6]=1 or the 6-bit adder carry-out=1): R=T, Q={Q[4:0],1}
  - else: R=R', Q={Q[4:0],0}
  - count++.
- RUN with count=5 (sixth iteration): go to DONE. On the same edge, quotient=final Q, remainder=final R[5:0], div_by_zero=0.
- DONE without start: go to IDLE the next cycle. Results hold.
- start while in RUN: ignored. No queueing; operands are not recaptured.
- The invariant R < D always holds, so R' ≤ 125 fits in 7 bits and the final remainder fits in 6 bits.

## Timing
- The accepting edge is E0.
- Nonzero divisor:
  - busy=1 for the 6 cycles following E0.
  - done=1 in the cycle following E6, so latency is 6 cycles.
- Zero divisor: done=1 in the cycle following E0 (latency 1). busy stays 0.
- done is high for exactly one cycle per accepted start.
- Back-to-back operation: a start sampled during the done cycle is accepted. busy rises the next cycle; prior results stay on the outputs until the new completion.
- Reset mid-operation takes effect immediately, asynchronously:
  - all outputs return to reset values and the in-flight result is discarded
  - after deassertion, the first start is accepted normally.
- Outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package alu_pkg:
  - WIDTH=6
  - state enum {IDLE, RUN, DONE}
  - DIV0_QUOTIENT=6'h3F.
- One sub-module, div_step, is the combinational single iteration:
  - inputs R', D; outputs T and no_borrow
  - implemented as the existing 6-bit ripple-carry adder on R'[5:0] + ~D with carry-in 1
  - no_borrow = carry-out OR R'[6].
- The top level holds the FSM, the counter, and the Q, R, D and result registers.

## Test plan
- 45/7 → done 6 cycles after start; quotient=6, remainder=3, div_by_zero=0; busy high for exactly 6 cycles.
- 63/1 → quotient=63, remainder=0. 5/9 → quotient=0, remainder=5. 63/63 → quotient=1, remainder=0.
- 20/0 → done 1 cycle after start; quotient=6'h3F, remainder=20, div_by_zero=1; busy never high.
- start pulsed again mid-run with 10/3 during an in-flight 45/7 → ignored; the result is 6 r 3 with a single done. Then start during the done cycle with 10/3 → quotient=3, remainder=1 six cycles later.
- Assert rst at cycle 3 of 50/4 → all outputs 0 immediately. After release, 50/4 → quotient=12, remainder=2.
- Exhaustive sweep of all 4096 operand pairs against a reference model, including div_by_zero for every divisor=0 case.
